// File: rtl/vwb_pkg.sv
// Shared types and constants for the vector register writeback arbiter.
// Holds the vector width, register index width, register count and source
// count, the entry type buffered per source, and a small helper for stepping
// a source index with wrap-around.
package vwb_pkg;

    localparam int XLEN_VEC       = 128;
    localparam int RFIDX_WIDTH    = 5;
    localparam int RFREG_NUM      = 32;
    localparam int NSRC           = 3;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int SRC_IDX_W      = $clog2(NSRC);

    typedef logic [RFIDX_WIDTH-1:0] vreg_idx_t;
    typedef logic [XLEN_VEC-1:0]    vreg_data_t;
    typedef logic [SRC_IDX_W-1:0]   src_idx_t;

    typedef struct packed {
        vreg_idx_t  vd;
        vreg_data_t data;
    } wb_entry_t;

    localparam vreg_idx_t VREG_ZERO = {RFIDX_WIDTH{1'b0}};

    // Next source index in round-robin order, wrapping after the last source.
    function automatic src_idx_t src_inc(input src_idx_t s);
        src_idx_t r;
        if (s == src_idx_t'(NSRC - 1)) begin
            r = {SRC_IDX_W{1'b0}};
        end else begin
            r = s + src_idx_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/vwb_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO of wb_entry_t.
// Ports: clk/rst (async active-high), enq/enq_entry (push), deq (pop, only
// when not empty), head (oldest entry), count/full/empty (occupancy), and
// ent_vd (destination registers of all slots, oldest first; slot j holds a
// live entry iff j < count).
module vwb_fifo
    import vwb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  wb_entry_t        enq_entry,
    input  logic             deq,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output vreg_idx_t        ent_vd [DEPTH]
);

    wb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers and occupancy; enqueue and dequeue may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= '{vd: VREG_ZERO, data: {XLEN_VEC{1'b0}}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= enq_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Destination registers in age order, for the busy mask.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_vd[j] = mem_r[rd_ptr_r + PTR_W'(j)].vd;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Vector writeback arbiter: buffers results from NSRC producers in per-source
// FIFOs and drains them round-robin onto the two register file write ports,
// never targeting the same nonzero register on both ports in one cycle.
// Ports: clk, rst (async active-high); src_valid/src_ready/src_vd/src_data
// (per-source producer handshake, source 0 in the LSBs); vwe, va5/vwd1
// (port 0), va6/vwd2 (port 1) registered write outputs; busy_mask (registers
// with a write still pending, for the issue hazard check).
module vreg_wb_arbiter
    import vwb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NSRC-1:0]             src_valid,
    output logic [NSRC-1:0]             src_ready,
    input  logic [NSRC*RFIDX_WIDTH-1:0] src_vd,
    input  logic [NSRC*XLEN_VEC-1:0]    src_data,
    output logic [1:0]                  vwe,
    output logic [RFIDX_WIDTH-1:0]      va5,
    output logic [RFIDX_WIDTH-1:0]      va6,
    output logic [XLEN_VEC-1:0]         vwd1,
    output logic [XLEN_VEC-1:0]         vwd2,
    output logic [RFREG_NUM-1:0]        busy_mask
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t        in_entry_s [NSRC];
    wb_entry_t        head_s     [NSRC];
    logic [CNT_W-1:0] count_s    [NSRC];
    vreg_idx_t        ent_vd_s   [NSRC][FIFO_DEPTH];
    logic [NSRC-1:0]  full_s;
    logic [NSRC-1:0]  empty_s;
    logic [NSRC-1:0]  enq_s;
    logic [NSRC-1:0]  deq_s;

    src_idx_t   rr_r;
    src_idx_t   rr_next_s;
    logic       g0_valid_s;
    logic       g1_valid_s;
    src_idx_t   g0_src_s;
    src_idx_t   g1_src_s;

    logic [1:0]           vwe_r;
    vreg_idx_t            va5_r;
    vreg_idx_t            va6_r;
    vreg_data_t           vwd1_r;
    vreg_data_t           vwd2_r;
    logic [RFREG_NUM-1:0] busy_s;

    // Ready follows the registered occupancy only and is held low during reset.
    assign src_ready = ~{NSRC{rst}} & ~full_s;
    assign enq_s     = src_valid & src_ready;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign in_entry_s[i].vd   = src_vd[i*RFIDX_WIDTH +: RFIDX_WIDTH];
        assign in_entry_s[i].data = src_data[i*XLEN_VEC +: XLEN_VEC];

        vwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .enq       (enq_s[i]),
            .enq_entry (in_entry_s[i]),
            .deq       (deq_s[i]),
            .head      (head_s[i]),
            .count     (count_s[i]),
            .full      (full_s[i]),
            .empty     (empty_s[i]),
            .ent_vd    (ent_vd_s[i])
        );
    end

    // Round-robin scan of FIFO heads: first live head to port 0, next live
    // head not clashing with the port-0 register to port 1.
    always_comb begin
        logic [SRC_IDX_W:0] sum_v;
        src_idx_t           src_v;
        sum_v      = {(SRC_IDX_W + 1){1'b0}};
        src_v      = {SRC_IDX_W{1'b0}};
        g0_valid_s = 1'b0;
        g1_valid_s = 1'b0;
        g0_src_s   = {SRC_IDX_W{1'b0}};
        g1_src_s   = {SRC_IDX_W{1'b0}};
        deq_s      = {NSRC{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            sum_v = {1'b0, rr_r} + (SRC_IDX_W + 1)'(k);
            if (sum_v >= (SRC_IDX_W + 1)'(NSRC)) begin
                sum_v = sum_v - (SRC_IDX_W + 1)'(NSRC);
            end else begin
                sum_v = sum_v;
            end
            src_v = sum_v[SRC_IDX_W-1:0];
            if (!empty_s[src_v]) begin
                if (!g0_valid_s) begin
                    g0_valid_s   = 1'b1;
                    g0_src_s     = src_v;
                    deq_s[src_v] = 1'b1;
                end else if (!g1_valid_s &&
                             ((head_s[src_v].vd != head_s[g0_src_s].vd) ||
                              (head_s[g0_src_s].vd == VREG_ZERO))) begin
                    g1_valid_s   = 1'b1;
                    g1_src_s     = src_v;
                    deq_s[src_v] = 1'b1;
                end else begin
                    deq_s[src_v] = deq_s[src_v];
                end
            end else begin
                deq_s[src_v] = deq_s[src_v];
            end
        end
        if (g1_valid_s) begin
            rr_next_s = src_inc(g1_src_s);
        end else if (g0_valid_s) begin
            rr_next_s = src_inc(g0_src_s);
        end else begin
            rr_next_s = rr_r;
        end
    end

    // Round-robin pointer and write-port registers; unused ports hold addr/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r   <= {SRC_IDX_W{1'b0}};
            vwe_r  <= 2'b00;
            va5_r  <= VREG_ZERO;
            va6_r  <= VREG_ZERO;
            vwd1_r <= {XLEN_VEC{1'b0}};
            vwd2_r <= {XLEN_VEC{1'b0}};
        end else begin
            rr_r  <= rr_next_s;
            vwe_r <= {g1_valid_s && (head_s[g1_src_s].vd != VREG_ZERO),
                      g0_valid_s && (head_s[g0_src_s].vd != VREG_ZERO)};
            if (g0_valid_s) begin
                va5_r  <= head_s[g0_src_s].vd;
                vwd1_r <= head_s[g0_src_s].data;
            end
            if (g1_valid_s) begin
                va6_r  <= head_s[g1_src_s].vd;
                vwd2_r <= head_s[g1_src_s].data;
            end
        end
    end

    // Pending-write mask: live FIFO entries plus writes on the ports this cycle.
    always_comb begin
        busy_s = {RFREG_NUM{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                if (CNT_W'(j) < count_s[i]) begin
                    busy_s[ent_vd_s[i][j]] = 1'b1;
                end else begin
                    busy_s = busy_s;
                end
            end
        end
        if (vwe_r[0]) begin
            busy_s[va5_r] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
        if (vwe_r[1]) begin
            busy_s[va6_r] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
        busy_s[0] = 1'b0;
    end

    assign vwe       = vwe_r;
    assign va5       = va5_r;
    assign va6       = va6_r;
    assign vwd1      = vwd1_r;
    assign vwd2      = vwd2_r;
    assign busy_mask = busy_s;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Self-checking bench for vreg_wb_arbiter: a directed vector table for the
// single/dual/conflict/register-0 cases, plus hand-written sequences for the
// reset-in-flight and three-source streaming corners.
module tb_vreg_wb_arbiter;
    import vwb_pkg::*;

    logic                        clk;
    logic                        rst;
    logic [NSRC-1:0]             src_valid;
    logic [NSRC-1:0]             src_ready;
    logic [NSRC*RFIDX_WIDTH-1:0] src_vd;
    logic [NSRC*XLEN_VEC-1:0]    src_data;
    logic [1:0]                  vwe;
    logic [RFIDX_WIDTH-1:0]      va5;
    logic [RFIDX_WIDTH-1:0]      va6;
    logic [XLEN_VEC-1:0]         vwd1;
    logic [XLEN_VEC-1:0]         vwd2;
    logic [RFREG_NUM-1:0]        busy_mask;

    int errors = 0;
    int checks = 0;

    vreg_wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_vd    (src_vd),
        .src_data  (src_data),
        .vwe       (vwe),
        .va5       (va5),
        .va6       (va6),
        .vwd1      (vwd1),
        .vwd2      (vwd2),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  vd0, vd1, vd2;
        logic [7:0]  t0, t1, t2;
        logic [1:0]  we;
        logic [4:0]  a5, a6;
        logic [7:0]  d1, d2;
        logic [2:0]  rdy;
        logic [31:0] busy;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [127:0] pat(input logic [7:0] t);
        return {16{t}};
    endfunction

    function automatic vec_t mk(input logic [2:0] v, input logic [4:0] vd0, vd1, vd2,
                                input logic [7:0] t0, t1, t2, input logic [1:0] we,
                                input logic [4:0] a5, a6, input logic [7:0] d1, d2,
                                input logic [2:0] rdy, input logic [31:0] busy);
        vec_t r;
        r.v = v; r.vd0 = vd0; r.vd1 = vd1; r.vd2 = vd2;
        r.t0 = t0; r.t1 = t1; r.t2 = t2; r.we = we;
        r.a5 = a5; r.a6 = a6; r.d1 = d1; r.d2 = d2;
        r.rdy = rdy; r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] vd0, vd1, vd2,
                         input logic [7:0] t0, t1, t2);
        src_valid = v;
        src_vd    = {vd2, vd1, vd0};
        src_data  = {pat(t2), pat(t1), pat(t0)};
    endtask

    // Streaming bookkeeping
    int acc [3];
    int wr  [3];
    int wt  [3];
    int max_wait;
    logic saw_notready;
    logic [2:0] rdy_snap;
    logic [2:0] granted;
    int pend [3];

    task automatic record(input logic [4:0] vd, input logic [127:0] data);
        int s;
        int n;
        s = (int'(vd) - 1) / 8;
        n = (int'(vd) - 1) % 8;
        if (vd == 5'd0 || s > 2) begin
            chk("stream_vd_range", 128'(vd), 128'd1);
        end else begin
            chk("stream_order", 128'(n), 128'(wr[s]));
            chk("stream_data", data, pat({s[3:0], n[3:0]}));
            wr[s]++;
            granted[s] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(src_ready), 128'(3'b000));
        chk("rst_vwe", 128'(vwe), 128'(2'b00));
        chk("rst_va5", 128'(va5), 128'd0);
        chk("rst_vwd1", vwd1, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ready", 128'(src_ready), 128'(3'b111));
        chk("idle_busy", 128'(busy_mask), 128'd0);
        chk("idle_vwe", 128'(vwe), 128'(2'b00));

        //            v       vd0    vd1    vd2    t0     t1     t2     we     a5     a6     d1     d2     rdy     busy
        vecs[0]  = mk(3'b001, 5'd5,  5'd0,  5'd0,  8'hA5, 8'h00, 8'h00, 2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 3'b111, 32'h0000_0020);
        vecs[1]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b01, 5'd5,  5'd0,  8'hA5, 8'h00, 3'b111, 32'h0000_0020);
        vecs[2]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b00, 5'd5,  5'd0,  8'hA5, 8'h00, 3'b111, 32'h0000_0000);
        vecs[3]  = mk(3'b100, 5'd0,  5'd0,  5'd12, 8'h00, 8'h00, 8'hC0, 2'b00, 5'd5,  5'd0,  8'hA5, 8'h00, 3'b111, 32'h0000_1000);
        vecs[4]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b01, 5'd12, 5'd0,  8'hC0, 8'h00, 3'b111, 32'h0000_1000);
        vecs[5]  = mk(3'b011, 5'd3,  5'd7,  5'd0,  8'h33, 8'h77, 8'h00, 2'b00, 5'd12, 5'd0,  8'hC0, 8'h00, 3'b111, 32'h0000_0088);
        vecs[6]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b11, 5'd3,  5'd7,  8'h33, 8'h77, 3'b111, 32'h0000_0088);
        vecs[7]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b00, 5'd3,  5'd7,  8'h33, 8'h77, 3'b111, 32'h0000_0000);
        vecs[8]  = mk(3'b100, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h0F, 2'b00, 5'd3,  5'd7,  8'h33, 8'h77, 3'b111, 32'h0000_0000);
        vecs[9]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b00, 5'd0,  5'd7,  8'h0F, 8'h77, 3'b111, 32'h0000_0000);
        vecs[10] = mk(3'b011, 5'd9,  5'd9,  5'd0,  8'h91, 8'h92, 8'h00, 2'b00, 5'd0,  5'd7,  8'h0F, 8'h77, 3'b111, 32'h0000_0200);
        vecs[11] = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b01, 5'd9,  5'd7,  8'h91, 8'h77, 3'b111, 32'h0000_0200);
        vecs[12] = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b01, 5'd9,  5'd7,  8'h92, 8'h77, 3'b111, 32'h0000_0200);
        vecs[13] = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b00, 5'd9,  5'd7,  8'h92, 8'h77, 3'b111, 32'h0000_0000);
        vecs[14] = mk(3'b001, 5'd1,  5'd0,  5'd0,  8'h11, 8'h00, 8'h00, 2'b00, 5'd9,  5'd7,  8'h92, 8'h77, 3'b111, 32'h0000_0002);
        vecs[15] = mk(3'b001, 5'd2,  5'd0,  5'd0,  8'h12, 8'h00, 8'h00, 2'b01, 5'd1,  5'd7,  8'h11, 8'h77, 3'b111, 32'h0000_0006);
        vecs[16] = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b01, 5'd2,  5'd7,  8'h12, 8'h77, 3'b111, 32'h0000_0004);
        vecs[17] = mk(3'b000, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 2'b00, 5'd2,  5'd7,  8'h12, 8'h77, 3'b111, 32'h0000_0000);

        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            drive(vecs[r].v, vecs[r].vd0, vecs[r].vd1, vecs[r].vd2, vecs[r].t0, vecs[r].t1, vecs[r].t2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vwe", r), 128'(vwe), 128'(vecs[r].we));
            chk($sformatf("v%0d_va5", r), 128'(va5), 128'(vecs[r].a5));
            chk($sformatf("v%0d_va6", r), 128'(va6), 128'(vecs[r].a6));
            chk($sformatf("v%0d_vwd1", r), vwd1, pat(vecs[r].d1));
            chk($sformatf("v%0d_vwd2", r), vwd2, pat(vecs[r].d2));
            chk($sformatf("v%0d_ready", r), 128'(src_ready), 128'(vecs[r].rdy));
            chk($sformatf("v%0d_busy", r), 128'(busy_mask), 128'(vecs[r].busy));
        end

        // Reset while results are in flight: writes drop at once, nothing after release
        @(negedge clk);
        drive(3'b111, 5'd20, 5'd21, 5'd22, 8'h20, 8'h21, 8'h22);
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_vwe_before", 128'(vwe), 128'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_vwe_async", 128'(vwe), 128'(2'b00));
        chk("mid_ready_in_rst", 128'(src_ready), 128'(3'b000));
        chk("mid_busy_in_rst", 128'(busy_mask), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_vwe", c), 128'(vwe), 128'(2'b00));
            chk($sformatf("post_rst%0d_busy", c), 128'(busy_mask), 128'd0);
        end

        // Three sources streaming 8 results each with distinct registers
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0; wr[i] = 0; wt[i] = 0;
        end
        max_wait = 0;
        saw_notready = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (wr[0] == 8 && wr[1] == 8 && wr[2] == 8) break;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (acc[i] < 8) begin
                    src_valid[i] = 1'b1;
                    src_vd[i*5 +: 5] = 5'(1 + i*8 + acc[i]);
                    src_data[i*128 +: 128] = pat({4'(i), 4'(acc[i])});
                end else begin
                    src_valid[i] = 1'b0;
                end
                pend[i] = acc[i] - wr[i];
            end
            rdy_snap = src_ready;
            if (rdy_snap != 3'b111) saw_notready = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (src_valid[i] && rdy_snap[i]) acc[i]++;
            end
            granted = 3'b000;
            if (vwe[0]) record(va5, vwd1);
            if (vwe[1]) record(va6, vwd2);
            for (int i = 0; i < 3; i++) begin
                if (pend[i] > 0 && !granted[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > max_wait) max_wait = wt[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream_count_src%0d", i), 128'(wr[i]), 128'd8);
        end
        chk("stream_backpressure_seen", 128'(saw_notready), 128'd1);
        chk("stream_wait_le2", 128'(max_wait <= 2), 128'd1);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("drain_ready", 128'(src_ready), 128'(3'b111));
        chk("drain_busy", 128'(busy_mask), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vreg_wb_arbiter.md
Name: vreg_wb_arbiter

Overview:
- Writeback stage between the vector functional units and the vector register file write side.
- Accepts results from NSRC producers (VALU, VMUL, VLSU) over valid/ready handshakes and buffers each in a small per-source FIFO.
- Arbitrates round-robin onto the register file's two write ports (write-enable pair, two write addresses, two write data buses), avoiding same-register conflicts.
- Exports a pending-write busy mask for the issue stage's hazard check.

Parameters:
- XLEN_VEC, 128, vector register width in bits
- RFIDX_WIDTH, 5, register index width
- RFREG_NUM, 32, number of vector registers
- NSRC, 3, number of producer sources
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- src_valid  in  NSRC  producer result valid, one bit per source
- src_ready  out  NSRC  source FIFO can accept
- src_vd  in  NSRC*RFIDX_WIDTH  destination register per source, packed, source 0 in the LSBs
- src_data  in  NSRC*XLEN_VEC  result data per source, packed
- vwe  out  2  write enables; bit0 = port 0, bit1 = port 1
- va5  out  RFIDX_WIDTH  port 0 write address
- va6  out  RFIDX_WIDTH  port 1 write address
- vwd1  out  XLEN_VEC  port 0 write data
- vwd2  out  XLEN_VEC  port 1 write data
- busy_mask  out  RFREG_NUM  registers with a pending write

Behaviour:
- Reset (async, immediate):
  - FIFOs empty; round-robin pointer rr = 0.
  - vwe = 0, va5 = va6 = 0, vwd1 = vwd2 = 0.
  - src_ready = 0 while rst is high; all 1 in the first cycle after release.
  - Reset mid-operation discards every buffered result and deasserts vwe immediately.
- Handshake:
  - Transfer occurs on a rising edge with src_valid[i] & src_ready[i].
  - src_ready[i] = (count_i < FIFO_DEPTH), derived from the registered count only. There is no same-cycle pass-through, and dequeue does not raise ready in the same cycle.
  - Enqueue and dequeue in the same cycle on one FIFO are legal whenever ready = 1.
- Arbitration (combinational on FIFO heads, every cycle):
  - Scan sources rr, rr+1, …, wrapping mod NSRC.
  - The first non-empty head is granted to port 0.
  - The next non-empty head whose vd differs from the port-0 vd (or the port-0 vd is 0) is granted to port 1.
  - A head that matches the port-0 vd is skipped this cycle, and the scan continues.
  - At most one grant per source per cycle.
  - rr advances to (last granted source + 1) mod NSRC; it is unchanged when nothing is granted.
- Output registers (load on rising edge):
  - vwe[p] = 1 iff port p was granted and the granted vd != 0.
  - va5/vwd1 take the port-0 head; va6/vwd2 take the port-1 head.
  - When a port is not granted, its address and data hold their previous values.
  - Granted entries are dequeued on the same edge.
- Register 0: a vd = 0 entry is granted and consumed like any other, but produces no write enable.
- Latency: a result accepted at edge k is visible on the write port from edge k+1 at the earliest, and the register file commits it at the falling edge within that cycle.
- Ordering: results from one source are written in acceptance order. There is no ordering guarantee across sources, except that the two ports never target the same nonzero register in one cycle.
- busy_mask: bit r = 1 iff any valid FIFO entry has vd = r, or (vwe[0] & va5 = r), or (vwe[1] & va6 = r). Bit 0 is always 0. The mask is combinational from registered state.

Decomposition:
- Shared package vwb_pkg:
  - XLEN_VEC, RFIDX_WIDTH, RFREG_NUM, NSRC
  - vreg_idx_t, vreg_data_t
  - wb_entry_t struct {vd, data}
- One sub-module, vwb_fifo: a parameterised FIFO_DEPTH-entry FIFO of wb_entry_t with count, full, empty, head, enq and deq, instantiated NSRC times.
- Arbiter, output registers and busy logic live in the top module.

Test Plan:
- Reset then idle → src_ready = 3'b111, vwe = 0, busy_mask = 0. Assert rst mid-stream with 2 entries buffered → vwe drops immediately, and no writes occur after release.
- Single write: src0 {vd=5, data=0xA5…} at edge k → at edge k+1, vwe = 2'b01, va5 = 5, vwd1 = 0xA5…; busy_mask[5] = 1 until edge k+2.
- Dual write: src0 vd=3 and src1 vd=7 in the same cycle, rr=0 → next cycle vwe = 2'b11, va5 = 3, va6 = 7; rr = 2.
- Conflict: src0 vd=9 and src1 vd=9, rr=0 → cycle 1: vwe = 2'b01 with src0 data; cycle 2: src1 written; writes are never on both ports with va5 = va6 = 9.
- Backpressure and fairness: all three sources stream 8 results each with distinct vds → src_ready toggles at depth 2, every result is written exactly once, per-source order is preserved, and no source waits more than 2 consecutive cycles.
- vd = 0: src2 sends vd=0 → entry consumed, vwe bit stays 0, busy_mask[0] = 0.
